// File: rtl/memory_access_stage.sv
// memory_access_stage
// -------------------
// MEM stage of a 5-stage RV32I pipeline. It takes the EX/MEM effective address
// and the forwarded store data, and issues the access on a req/gnt/rvalid data
// memory port. Load data is formatted (byte/half/word, sign or zero extended)
// and registered for writeback. The pipeline is stalled while an access is
// outstanding. Misaligned or illegal accesses are flagged and never issued.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   MEM_valid_i            instruction in MEM is valid (not a bubble)
//   MEM_MemRead_i          instruction is a load
//   MEM_MemWrite_i         instruction is a store
//   MEM_funct3_i           access size / signedness (instruction[14:12])
//   MEM_alu_result_i       effective byte address
//   MEM_rd_data2_i         store data (already forwarded)
//   MEM_stall_o            hold the front of the pipeline, bubble into MEM/WB
//   MEM_load_data_o        registered, formatted load result
//   MEM_access_fault_o     misaligned/illegal access (combinational)
//   dmem_req_o ... dmem_be_o   request side of the data-memory port
//   dmem_gnt_i             request accepted this cycle
//   dmem_rvalid_i          read data valid
//   dmem_rdata_i           read data word
//
// Handshake: a request is transferred on a cycle where dmem_req_o and
// dmem_gnt_i are both high. While dmem_req_o is high the address, write
// enable, byte enables and write data stay stable. Stores complete on the
// grant; loads complete on the first dmem_rvalid_i after the grant.
module memory_access_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_valid_i,
    input  logic                  MEM_MemRead_i,
    input  logic                  MEM_MemWrite_i,
    input  logic [2:0]            MEM_funct3_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_rd_data2_i,
    output logic                  MEM_stall_o,
    output logic [DATA_WIDTH-1:0] MEM_load_data_o,
    output logic                  MEM_access_fault_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              off_q, off_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;

    logic                    access;
    logic                    bad_kind;
    logic                    misaligned;
    logic                    fault;
    logic                    start;
    logic [3:0]              be_new;
    logic [DATA_WIDTH-1:0]   wdata_new;
    logic [DATA_WIDTH-1:0]   rdata_shifted;
    logic [DATA_WIDTH-1:0]   load_fmt;

    // Legal loads: funct3 000,001,010,100,101. Legal stores: 000,001,010.
    assign access     = MEM_valid_i & (MEM_MemRead_i | MEM_MemWrite_i);
    assign bad_kind   = (MEM_MemRead_i & MEM_MemWrite_i)
                      | (MEM_MemRead_i & ((MEM_funct3_i == 3'b011) | (MEM_funct3_i[2:1] == 2'b11)))
                      | (MEM_MemWrite_i & (MEM_funct3_i[2] | (MEM_funct3_i[1:0] == 2'b11)));
    assign misaligned = ((MEM_funct3_i[1:0] == 2'b01) & MEM_alu_result_i[0])
                      | ((MEM_funct3_i[1:0] == 2'b10) & (MEM_alu_result_i[1:0] != 2'b00));
    assign fault      = access & (bad_kind | misaligned);
    assign start      = access & ~fault;

    assign MEM_access_fault_o = fault;

    // Lane placement: narrow store data is replicated across all lanes so the
    // byte enables alone select where it lands.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = MEM_rd_data2_i;
        case (MEM_funct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << MEM_alu_result_i[1:0];
                wdata_new = {4{MEM_rd_data2_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << MEM_alu_result_i[1:0];
                wdata_new = {2{MEM_rd_data2_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = MEM_rd_data2_i;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend. Word accesses are
    // aligned, so the shift is zero for them.
    always_comb begin
        rdata_shifted = dmem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_fmt = {24'h000000, rdata_shifted[7:0]};
            3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_fmt = {16'h0000, rdata_shifted[15:0]};
            default: load_fmt = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
                    we_d     = MEM_MemWrite_i;
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                    funct3_d = MEM_funct3_i;
                    off_d    = MEM_alu_result_i[1:0];
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid_i) begin
                    load_data_d = load_fmt;
                    state_d     = DONE;
                end
            end
            // The completed instruction is still on the inputs here; going
            // straight to IDLE without looking at them prevents a re-issue.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
        end
    end

    // The stall must rise in the very cycle the access is seen, before the
    // FSM has left IDLE, hence the dependency on start.
    always_comb begin
        MEM_stall_o = 1'b0;
        case (state_q)
            IDLE:     MEM_stall_o = start;
            REQ:      MEM_stall_o = 1'b1;
            WAIT_RSP: MEM_stall_o = 1'b1;
            default:  MEM_stall_o = 1'b0;
        endcase
        if (rst) begin
            MEM_stall_o = 1'b0;
        end
    end

    assign dmem_req_o      = (state_q == REQ) & ~rst;
    assign dmem_we_o       = we_q;
    assign dmem_addr_o     = addr_q;
    assign dmem_be_o       = be_q;
    assign dmem_wdata_o    = wdata_q;
    assign MEM_load_data_o = load_data_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Consumes the EX-produced ALU result, latched in EX/MEM, as the effective address, plus the forwarded rs2 value as store data.
- Drives a req/gnt/rvalid data-memory port. Formats load data (byte/half/word, sign/zero extension) for writeback.
- Stalls the pipeline while an access is outstanding.
- Flags misaligned or illegal accesses instead of issuing them.

Parameters:
- DATA_WIDTH, 32, datapath/address width (from defines; only 32 supported)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- MEM_valid_i  input  1  instruction in MEM is valid (not a bubble)
- MEM_MemRead_i  input  1  instruction is a load
- MEM_MemWrite_i  input  1  instruction is a store
- MEM_funct3_i  input  3  instruction[14:12]: access size/signedness
- MEM_alu_result_i  input  32  effective address from EX
- MEM_rd_data2_i  input  32  store data (already forwarded)
- MEM_stall_o  output  1  hold PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB
- MEM_load_data_o  output  32  formatted load result
- MEM_access_fault_o  output  1  misaligned/illegal access, combinational
- dmem_req_o  output  1  request valid
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  32  word address, bits [1:0] = 0
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_be_o  output  4  byte enables
- dmem_gnt_i  input  1  request accepted this cycle
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  32  read data word

Behaviour:
- access = MEM_valid_i & (MEM_MemRead_i | MEM_MemWrite_i).
- fault = access & any of:
  - MemRead & MemWrite both high
  - load funct3 in {011,110,111}
  - store funct3 not in {000,001,010}
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
- Faulting access: no dmem request, no stall. MEM_access_fault_o=1 in that cycle. MEM_load_data_o unchanged.
- FSM states: IDLE, REQ, WAIT_RSP, DONE. Reset: state=IDLE, MEM_load_data_o=0, captured regs=0.
- IDLE:
  - On access & !fault: capture addr, we, be, wdata, funct3, addr[1:0]; go to REQ. MEM_stall_o=1 combinationally in this cycle.
  - Otherwise stay in IDLE with stall 0.
  - dmem_rvalid_i is ignored in IDLE.
- REQ:
  - dmem_req_o=1; addr/we/be/wdata driven from captured regs and held stable until gnt. Stall 1.
  - On gnt with we=1: go to DONE (stores complete on grant).
  - On gnt with we=0: go to WAIT_RSP.
- WAIT_RSP:
  - Stall 1, req 0. rvalid is legal no earlier than the cycle after gnt.
  - On rvalid: register the formatted rdata into MEM_load_data_o; go to DONE.
- DONE:
  - Stall 0, so the pipeline advances this cycle. The instruction on the inputs is still the completed one and must not retrigger.
  - Go to IDLE unconditionally.
- Minimum stall: load 3 cycles (access, REQ w/ gnt, rvalid); store 2 cycles.
- Store formatting:
  - SB: be=0001<<off, wdata={4{byte}}
  - SH: be=0011<<off, wdata={2{half}}
  - SW: be=1111, wdata=rs2
- Load formatting uses the captured offset:
  - LB/LBU: byte lane off, sign-/zero-extend
  - LH/LHU: lanes off+1:off, sign-/zero-extend
  - LW: full word
- Non-memory instructions and bubbles: no req, stall 0, load_data held.
- rst asserted mid-access: state→IDLE at that edge. dmem_req_o and stall are forced 0 while rst=1. A late rvalid afterwards is ignored.
- gnt while not in REQ is ignored.

Test Plan:
- LW addr 0x100, gnt in REQ, rvalid 1 cycle later with rdata 0xDEADBEEF -> dmem_addr_o=0x100, be=1111, we=0. Stall high exactly 3 cycles. Load_data=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 -> load_data=0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x102, rdata 0x8001xxxx -> 0xFFFF8001.
- SB addr 0x21, rs2=0x000000AB, gnt delayed 3 cycles -> req/addr=0x20/be=0010/wdata=0xABABABAB stable until gnt. Stall high 5 cycles, no WAIT_RSP entered.
- SW addr 0x102 and LH addr 0x101 -> fault=1 same cycle, no req, stall 0, load_data unchanged.
- rst pulsed while in WAIT_RSP, rvalid arrives next cycle -> state IDLE, stall 0, load_data=0, rvalid ignored.
- Bubble (valid=0) with MemRead=1, and an ALU op -> no req, stall 0, fault 0.
